// File: rtl/riscv_sp_cdb_pkg.sv
// Common Data Bus shared types: requester ids, widths and broadcast bundle.
// Used by the CDB arbiter and by anything that consumes the broadcast.
package riscv_sp_cdb_pkg;

  localparam int CDB_TAG_W   = 6;
  localparam int CDB_DATA_W  = 32;
  localparam int NUM_CDB_REQ = 4;
  localparam int CDB_SRC_W   = $clog2(NUM_CDB_REQ);

  typedef enum logic [CDB_SRC_W-1:0] {
    REQ_INT  = 2'd0,
    REQ_MULT = 2'd1,
    REQ_DIV  = 2'd2,
    REQ_MEM  = 2'd3
  } req_id_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr wins.
// Produces a one-hot grant, the encoded winner and an any-grant flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);

  logic [ID_W:0]   w_idx;
  logic [ID_W-1:0] w_sel;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    w_sel   = '0;
    if (i_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = {1'b0, i_ptr} + (ID_W+1)'(k);
        if (w_idx >= (ID_W+1)'(NUM_REQ))
          w_idx = w_idx - (ID_W+1)'(NUM_REQ);
        w_sel = w_idx[ID_W-1:0];
        if (!o_any && i_req[w_sel]) begin
          o_grant[w_sel] = 1'b1;
          o_id           = w_sel;
          o_any          = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among execution units and a registered
// one-cycle broadcast of the winner's tag/data/source.
module cdb_arbiter
  import riscv_sp_cdb_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [SRC_W-1:0]   r_rr_ptr;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [SRC_W-1:0]   r_src;

  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_id;
  logic               w_any;
  logic               w_en;
  logic [SRC_W-1:0]   w_ptr_nxt;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_data;

  // Reset also blocks grants so no requester sees a handshake while held.
  assign w_en = ~flush & ~rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (SRC_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  assign grant  = w_grant;
  assign w_tag  = req_tag[w_id*TAG_W +: TAG_W];
  assign w_data = req_data[w_id*DATA_W +: DATA_W];

  always_comb begin
    w_ptr_nxt = w_id + SRC_W'(1);
    if (w_id == SRC_W'(NUM_REQ-1))
      w_ptr_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
      r_src    <= '0;
    end else if (w_any) begin
      r_rr_ptr <= w_ptr_nxt;
      r_valid  <= 1'b1;
      r_tag    <= w_tag;
      r_data   <= w_data;
      r_src    <= w_id;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_data;
  assign cdb_src   = r_src;

endmodule
